// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration loader: FSM state encoding,
// default sync marker and chain geometry helper.
package cfg_loader_pkg;

  localparam int         CHAIN_LEN_DEFAULT = 64;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  function automatic int chain_bytes(input int chain_len);
    return chain_len / 8;
  endfunction

endpackage

// File: rtl/cfg_loader_if.sv
// Byte stream from the flash reader into the configuration loader.
interface cfg_loader_if;
  // A byte transfers on a rising CLK edge where IN_VALID && IN_READY; the source
  // holds IN_DATA stable while IN_VALID is high and IN_READY is low.
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;

  modport master (output IN_DATA, output IN_VALID, input IN_READY);
  modport slave  (input IN_DATA, input IN_VALID, output IN_READY);
endinterface

// File: rtl/cfg_piso.sv
// 8-bit parallel-in serial-out stage, LSB first, with bit index and last-bit flag.
module cfg_piso (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clr,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] load_data,
  output logic       dout,
  output logic       last
);

  logic [7:0] shreg;
  logic [2:0] bit_idx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (load) begin
      shreg   <= load_data;
      bit_idx <= '0;
    end else if (shift) begin
      shreg   <= {1'b0, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  assign dout = shreg[0];
  assign last = (bit_idx == 3'd7);

endmodule

// File: rtl/cfg_loader.sv
// Frame parser that validates sync/length/checksum, serialises the payload into
// the fabric configuration chain and releases global reset once latched.
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int         CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            RESTART,
  cfg_loader_if.slave     in_if,
  output logic            CFG_DOUT,
  output logic            CFG_SHIFT,
  output logic            CFG_LATCH,
  output logic            GSR_N,
  output logic            DONE,
  output logic            ERROR,
  output state_t          STATE
);

  localparam int              CHAIN_BYTES = chain_bytes(CHAIN_LEN);
  localparam int              RW          = $clog2(CHAIN_BYTES + 1);
  localparam logic [15:0]     LEN_EXP     = 16'(CHAIN_BYTES);
  localparam logic [RW-1:0]   REM_INIT    = RW'(CHAIN_BYTES);

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          latch_q, latch_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [7:0]    acc_q, acc_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          piso_load, piso_shift, piso_last;
  logic          accept;

  assign accept = in_if.IN_VALID && in_ready_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      latch_q    <= 1'b0;
      len_hi_q   <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      latch_q    <= latch_d;
      len_hi_q   <= len_hi_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    latch_d    = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    in_ready_d = 1'b0;

    if (RESTART) begin
      state_d  = ST_IDLE;
      len_hi_d = '0;
      acc_d    = '0;
      rem_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept && in_if.IN_DATA == SYNC_BYTE) state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_d = in_if.IN_DATA;
            state_d  = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            if ({len_hi_q, in_if.IN_DATA} == LEN_EXP) begin
              rem_d   = REM_INIT;
              acc_d   = '0;
              state_d = ST_PAYLOAD;
            end else begin
              state_d = ST_ERR;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            piso_load = 1'b1;
            acc_d     = acc_q + in_if.IN_DATA;
            rem_d     = rem_q - RW'(1);
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          piso_shift = 1'b1;
          if (piso_last) state_d = (rem_q == '0) ? ST_CHECK : ST_PAYLOAD;
        end
        ST_CHECK: begin
          // The latch pulse occupies one extra CHECK cycle so DONE follows it.
          if (latch_q) begin
            state_d = ST_DONE;
          end else if (accept) begin
            if (in_if.IN_DATA == acc_q) latch_d = 1'b1;
            else                        state_d = ST_ERR;
          end
        end
        ST_DONE: state_d = ST_DONE;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end

    // Ready is registered from the next state, keeping IN_VALID off the ready path.
    in_ready_d = !latch_d &&
                 (state_d == ST_IDLE || state_d == ST_LEN_HI || state_d == ST_LEN_LO ||
                  state_d == ST_PAYLOAD || state_d == ST_CHECK);
  end

  cfg_piso u_piso (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (RESTART),
    .load      (piso_load),
    .shift     (piso_shift),
    .load_data (in_if.IN_DATA),
    .dout      (CFG_DOUT),
    .last      (piso_last)
  );

  assign in_if.IN_READY = in_ready_q;
  assign CFG_SHIFT      = (state_q == ST_SHIFT);
  assign CFG_LATCH      = latch_q;
  assign DONE           = (state_q == ST_DONE);
  assign GSR_N          = (state_q == ST_DONE);
  assign ERROR          = (state_q == ST_ERR);
  assign STATE          = state_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboarded bench for cfg_loader: expected chain bits and frame outcomes are
// queued by the stimulus and consumed by an independent negedge monitor.
module tb_cfg_loader;
  import cfg_loader_pkg::*;

  localparam logic [1:0] EVT_DONE = 2'b01;  // {ERROR, DONE}
  localparam logic [1:0] EVT_ERR  = 2'b10;

  // ---------------- clock / reset ----------------
  logic   CLK = 1'b0;
  logic   RST_N = 1'b0;
  logic   RESTART = 1'b0;
  logic   CFG_DOUT, CFG_SHIFT, CFG_LATCH, GSR_N, DONE, ERROR;
  state_t STATE;

  always #5 CLK = ~CLK;

  cfg_loader_if in_if ();

  cfg_loader #(.CHAIN_LEN(64), .SYNC_BYTE(8'hA5)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RESTART   (RESTART),
    .in_if     (in_if),
    .CFG_DOUT  (CFG_DOUT),
    .CFG_SHIFT (CFG_SHIFT),
    .CFG_LATCH (CFG_LATCH),
    .GSR_N     (GSR_N),
    .DONE      (DONE),
    .ERROR     (ERROR),
    .STATE     (STATE)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  logic [1:0] exp_evt_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         shift_cnt = 0;
  int         latch_cnt = 0;

  logic [7:0] payload [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic push_payload_bits(input int nbits);
    logic [7:0] b;
    for (int i = 0; i < nbits; i++) begin
      b = payload[i / 8];
      exp_q.push_back(b[i % 8]);
    end
  endtask

  // Monitor: every shift pulse consumes one expected bit; every DONE/ERROR rise
  // consumes one expected outcome.
  initial begin
    logic [0:0] e;
    logic [1:0] ev;
    logic       prev_done, prev_err, prev_latch;
    prev_done = 1'b0; prev_err = 1'b0; prev_latch = 1'b0;
    forever begin
      @(negedge CLK);
      if (CFG_SHIFT) begin
        shift_cnt++;
        if (exp_q.size() == 0) chk("spurious_shift", 32'(CFG_SHIFT), 0);
        else begin
          e = exp_q.pop_front();
          chk("cfg_dout", 32'(CFG_DOUT), 32'(e));
        end
      end
      if (CFG_LATCH) latch_cnt++;
      if ((DONE && !prev_done) || (ERROR && !prev_err)) begin
        if (DONE) chk("latch_before_done", 32'(prev_latch), 1);
        if (exp_evt_q.size() == 0) chk("spurious_outcome", 32'({ERROR, DONE}), 0);
        else begin
          ev = exp_evt_q.pop_front();
          chk("outcome", 32'({ERROR, DONE}), 32'(ev));
        end
      end
      prev_done  = DONE;
      prev_err   = ERROR;
      prev_latch = CFG_LATCH;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Callers enter at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   n;
    repeat (gap) @(posedge CLK);
    if (gap > 0) #1;
    in_if.IN_DATA  = b;
    in_if.IN_VALID = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      rdy = in_if.IN_READY;
      @(posedge CLK);
      n++;
    end while (!rdy && n < 100);
    if (!rdy) chk("accept_timeout", 32'(rdy), 1);
    #1 in_if.IN_VALID = 1'b0;
  endtask

  task automatic send_head_payload(input int maxgap);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(8'h00, $urandom_range(0, maxgap));
    send_byte(8'h08, $urandom_range(0, maxgap));
    for (int i = 0; i < 8; i++) send_byte(payload[i], $urandom_range(0, maxgap));
  endtask

  task automatic do_restart();
    @(posedge CLK);
    #1 RESTART = 1'b1;
    @(posedge CLK);
    #1 RESTART = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(DONE || ERROR) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("done_or_error_seen", 32'(DONE | ERROR), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_if.IN_READY), 0);
    chk({tag, "_cfg_dout"},  32'(CFG_DOUT), 0);
    chk({tag, "_cfg_shift"}, 32'(CFG_SHIFT), 0);
    chk({tag, "_cfg_latch"}, 32'(CFG_LATCH), 0);
    chk({tag, "_gsr_n"},     32'(GSR_N), 0);
    chk({tag, "_done"},      32'(DONE), 0);
    chk({tag, "_error"},     32'(ERROR), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_s, base_l, n;
    in_if.IN_DATA  = 8'h00;
    in_if.IN_VALID = 1'b0;

    // Reset values, then ready on the first edge after release.
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("ready_after_release", 32'(in_if.IN_READY), 1);
    chk("idle_after_release", 32'(STATE), 32'(ST_IDLE));

    // Good frame back to back, checksum 0x24.
    base_s = shift_cnt; base_l = latch_cnt;
    push_payload_bits(64);
    exp_evt_q.push_back(EVT_DONE);
    send_head_payload(0);
    send_byte(8'h24, 0);
    @(negedge CLK);
    chk("latch_after_csum", 32'(CFG_LATCH), 1);
    chk("done_not_yet", 32'(DONE), 0);
    @(negedge CLK);
    chk("latch_one_cycle", 32'(CFG_LATCH), 0);
    chk("good_done", 32'(DONE), 1);
    chk("good_gsr_n", 32'(GSR_N), 1);
    chk("good_in_ready", 32'(in_if.IN_READY), 0);
    chk("good_shift_count", 32'(shift_cnt - base_s), 64);
    chk("good_latch_count", 32'(latch_cnt - base_l), 1);

    // Bad checksum 0x25.
    do_restart();
    @(negedge CLK);
    chk("restart_clears_done", 32'(DONE), 0);
    chk("restart_gsr_low", 32'(GSR_N), 0);
    @(posedge CLK); #1;
    base_s = shift_cnt; base_l = latch_cnt;
    push_payload_bits(64);
    exp_evt_q.push_back(EVT_ERR);
    send_head_payload(0);
    send_byte(8'h25, 0);
    wait_end();
    @(negedge CLK);
    chk("badsum_error", 32'(ERROR), 1);
    chk("badsum_gsr_n", 32'(GSR_N), 0);
    chk("badsum_in_ready", 32'(in_if.IN_READY), 0);
    chk("badsum_no_latch", 32'(latch_cnt - base_l), 0);
    chk("badsum_shift_count", 32'(shift_cnt - base_s), 64);

    // Wrong length 00 07.
    do_restart();
    base_s = shift_cnt;
    exp_evt_q.push_back(EVT_ERR);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h07, 0);
    @(negedge CLK);
    chk("badlen_error_next", 32'(ERROR), 1);
    chk("badlen_state", 32'(STATE), 32'(ST_ERR));
    chk("badlen_no_shift", 32'(shift_cnt - base_s), 0);

    // Good frame with random valid gaps.
    do_restart();
    base_s = shift_cnt; base_l = latch_cnt;
    push_payload_bits(64);
    exp_evt_q.push_back(EVT_DONE);
    send_head_payload(3);
    send_byte(8'h24, $urandom_range(0, 3));
    wait_end();
    @(negedge CLK);
    chk("gaps_done", 32'(DONE), 1);
    chk("gaps_shift_count", 32'(shift_cnt - base_s), 64);
    chk("gaps_latch_count", 32'(latch_cnt - base_l), 1);

    // RESTART in the 4th shift cycle of byte 3, then a full frame.
    do_restart();
    base_l = latch_cnt;
    push_payload_bits(20);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    send_byte(payload[0], 0);
    send_byte(payload[1], 0);
    send_byte(payload[2], 0);
    repeat (3) @(posedge CLK);
    #1 RESTART = 1'b1;
    @(posedge CLK);
    #1 RESTART = 1'b0;
    @(negedge CLK);
    chk("abort_shift_low", 32'(CFG_SHIFT), 0);
    chk("abort_state_idle", 32'(STATE), 32'(ST_IDLE));
    chk("abort_no_latch", 32'(latch_cnt - base_l), 0);
    @(posedge CLK); #1;
    base_s = shift_cnt; base_l = latch_cnt;
    push_payload_bits(64);
    exp_evt_q.push_back(EVT_DONE);
    send_head_payload(0);
    send_byte(8'h24, 0);
    wait_end();
    @(negedge CLK);
    chk("reload_done", 32'(DONE), 1);
    chk("reload_shift_count", 32'(shift_cnt - base_s), 64);
    chk("reload_latch_count", 32'(latch_cnt - base_l), 1);

    // Asynchronous reset while waiting in PAYLOAD after byte 1.
    do_restart();
    push_payload_bits(8);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    send_byte(payload[0], 0);
    n = 0;
    while (STATE != ST_PAYLOAD && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_payload", 32'(STATE), 32'(ST_PAYLOAD));
    #2 RST_N = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    chk("async_rst_state", 32'(STATE), 32'(ST_IDLE));
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_rerelease", 32'(in_if.IN_READY), 1);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    @(negedge CLK);
    chk("discard_stays_idle", 32'(STATE), 32'(ST_IDLE));
    @(posedge CLK); #1;
    base_s = shift_cnt; base_l = latch_cnt;
    push_payload_bits(64);
    exp_evt_q.push_back(EVT_DONE);
    send_head_payload(0);
    send_byte(8'h24, 0);
    wait_end();
    @(negedge CLK);
    chk("post_reset_done", 32'(DONE), 1);
    chk("post_reset_gsr_n", 32'(GSR_N), 1);
    chk("post_reset_shift_count", 32'(shift_cnt - base_s), 64);

    // ---------------- final report ----------------
    repeat (3) @(negedge CLK);
    chk("bit_queue_drained", 32'(exp_q.size()), 0);
    chk("event_queue_drained", 32'(exp_evt_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
